// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arbiter_pkg;
  localparam int AW_DEF           = 8;
  localparam int DW_DEF           = 8;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_HOST = 1'b1} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the arbiter; slave = arbiter view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  ram_rdata,
    output cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output ram_rdata,
    input  cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating count of CPU grants taken while the host was waiting.
module starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic atLimit
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign atLimit = (count == CW'(LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                count <= '0;
    else if (clr)             count <= '0;
    else if (inc && !atLimit) count <= count + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU has priority, host is promoted after
// STARVE_LIMIT consecutive CPU grants. One access in flight at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  state_t        stateQ, stateD;
  owner_t        ownerQ;
  logic          cmdWe;
  logic [AW-1:0] cmdAddr;
  logic [DW-1:0] cmdWdata;
  logic          grantCpu, grantHost, hostWins, atLimit;

  assign hostWins = bus.host_req && (!bus.cpu_req || atLimit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD    = stateQ;
    grantCpu  = 1'b0;
    grantHost = 1'b0;
    case (stateQ)
      IDLE: begin
        if (bus.cpu_req || bus.host_req) begin
          stateD    = ACCESS;
          grantHost = hostWins;
          grantCpu  = !hostWins;
        end
      end
      ACCESS:  stateD = cmdWe ? IDLE : RESP;
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ownerQ   <= OWN_CPU;
      cmdWe    <= 1'b0;
      cmdAddr  <= '0;
      cmdWdata <= '0;
    end else if (grantCpu) begin
      ownerQ   <= OWN_CPU;
      cmdWe    <= bus.cpu_we;
      cmdAddr  <= bus.cpu_addr;
      cmdWdata <= bus.cpu_wdata;
    end else if (grantHost) begin
      ownerQ   <= OWN_HOST;
      cmdWe    <= bus.host_we;
      cmdAddr  <= bus.host_addr;
      cmdWdata <= bus.host_wdata;
    end
  end

  // rdata is only loaded on the RESP edge, so it holds between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_gnt     <= 1'b0;
      bus.host_gnt    <= 1'b0;
      bus.cpu_rvalid  <= 1'b0;
      bus.host_rvalid <= 1'b0;
      bus.rdata       <= '0;
    end else begin
      bus.cpu_gnt     <= grantCpu;
      bus.host_gnt    <= grantHost;
      bus.cpu_rvalid  <= (stateQ == RESP) && (ownerQ == OWN_CPU);
      bus.host_rvalid <= (stateQ == RESP) && (ownerQ == OWN_HOST);
      if (stateQ == RESP) bus.rdata <= bus.ram_rdata;
    end
  end

  // RAM strobes decode straight from state so reset kills them at once
  assign bus.ram_en    = (stateQ == ACCESS);
  assign bus.ram_we    = (stateQ == ACCESS) && cmdWe;
  assign bus.ram_addr  = cmdAddr;
  assign bus.ram_wdata = cmdWdata;

  starve_counter #(.LIMIT(STARVE_LIMIT)) uStarve (
    .clk     (clk),
    .reset   (reset),
    .clr     (grantHost || ((stateQ == IDLE) && !bus.host_req)),
    .inc     (grantCpu && bus.host_req),
    .atLimit (atLimit)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with grant/read scoreboards and a RAM model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   errs  = 0;

  typedef struct {
    bit         host;
    logic [7:0] data;
  } rd_t;

  rd_t  rdQ[$];
  bit   gntQ[$];
  logic [7:0] mem [256];

  mem_arbiter_if #(.AW(8), .DW(8)) bus();

  mem_arbiter #(.AW(8), .DW(8), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // synchronous-read RAM
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: grants and read responses are popped in arrival order
  always @(negedge clk) begin
    bit  h;
    rd_t e;
    if (!reset) begin
      if (bus.cpu_gnt || bus.host_gnt) begin
        chk("gnt_exclusive", 32'(bus.cpu_gnt & bus.host_gnt), 0);
        chk("gnt_pending", 32'(gntQ.size() != 0), 1);
        if (gntQ.size() != 0) begin
          h = gntQ.pop_front();
          chk("gnt_owner", 32'(bus.host_gnt), 32'(h));
        end
      end
      if (bus.cpu_rvalid || bus.host_rvalid) begin
        chk("rv_exclusive", 32'(bus.cpu_rvalid & bus.host_rvalid), 0);
        chk("rv_pending", 32'(rdQ.size() != 0), 1);
        if (rdQ.size() != 0) begin
          e = rdQ.pop_front();
          chk("rv_owner", 32'(bus.host_rvalid), 32'(e.host));
          chk("rv_data", 32'(bus.rdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.cpu_req = 0;  bus.cpu_we = 0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem[i] = 8'hA0 + 8'(i);
    mem[8'h10] = 8'h5A;
    mem[8'h30] = 8'h11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",    32'({bus.cpu_gnt, bus.host_gnt}), 0);
    chk("rst_rvalid", 32'({bus.cpu_rvalid, bus.host_rvalid}), 0);
    chk("rst_ram",    32'({bus.ram_en, bus.ram_we}), 0);
    chk("rst_addr",   32'(bus.ram_addr), 0);
    chk("rst_rdata",  32'(bus.rdata), 0);
    chk("rst_starve", 32'(dut.uStarve.count), 0);
    reset = 1'b0;
    tick();

    // CPU read of 0x10: gnt/ram_en at +1, RAM samples at +2, rvalid at +3
    gntQ.push_back(1'b0);
    rdQ.push_back('{1'b0, 8'h5A});
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10;
    tick();
    chk("rd_gnt",    32'(bus.cpu_gnt), 1);
    chk("rd_ram_en", 32'(bus.ram_en), 1);
    chk("rd_ram_we", 32'(bus.ram_we), 0);
    chk("rd_addr",   32'(bus.ram_addr), 32'h10);
    bus.cpu_req = 0;
    tick();
    chk("rd_gnt_pulse", 32'(bus.cpu_gnt), 0);
    chk("rd_resp_en",   32'(bus.ram_en), 0);
    tick();
    chk("rd_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("rd_rdata",  32'(bus.rdata), 32'h5A);
    tick();

    // host write 0x20 <= 0xC3, then CPU reads it back
    gntQ.push_back(1'b1);
    bus.host_req = 1; bus.host_we = 1; bus.host_addr = 8'h20; bus.host_wdata = 8'hC3;
    tick();
    chk("wr_gnt",   32'(bus.host_gnt), 1);
    chk("wr_we",    32'(bus.ram_we), 1);
    chk("wr_wdata", 32'(bus.ram_wdata), 32'hC3);
    chk("wr_addr",  32'(bus.ram_addr), 32'h20);
    bus.host_req = 0;
    tick();
    chk("wr_we_off", 32'(bus.ram_we), 0);
    chk("wr_mem",    32'(mem[8'h20]), 32'hC3);
    gntQ.push_back(1'b0);
    rdQ.push_back('{1'b0, 8'hC3});
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h20;
    tick();
    bus.cpu_req = 0;
    repeat (3) tick();

    // both requesters hold req: four CPU grants, then one host grant
    for (int g = 0; g < 10; g++) begin
      gntQ.push_back(g % 5 == 4);
      rdQ.push_back('{(g % 5 == 4), ((g % 5 == 4) ? 8'hC3 : 8'h5A)});
    end
    bus.cpu_req = 1;  bus.cpu_we = 0;  bus.cpu_addr = 8'h10;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 8'h20;
    for (int g = 0; g < 10; g++) begin
      tick();
      chk("starve_cnt", 32'(dut.uStarve.count), (g % 5 == 4) ? 0 : 32'(g % 5 + 1));
      tick();
      tick();
    end
    bus.cpu_req = 0; bus.host_req = 0;
    repeat (3) tick();

    // reset in the middle of a write ACCESS aborts it
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h30; bus.cpu_wdata = 8'h99;
    tick();
    chk("abort_gnt", 32'(bus.cpu_gnt), 1);
    chk("abort_we",  32'(bus.ram_we), 1);
    bus.cpu_req = 0;
    #2 reset = 1'b1;
    #1;
    chk("abort_we_async", 32'(bus.ram_we), 0);
    chk("abort_en_async", 32'(bus.ram_en), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) tick();
    chk("abort_mem", 32'(mem[8'h30]), 32'h11);

    // reset during RESP suppresses the rvalid pulse
    gntQ.push_back(1'b0);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h10;
    tick();
    bus.cpu_req = 0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("resp_rst_rv", 32'(bus.cpu_rvalid), 0);
    @(posedge clk);
    #1;
    chk("resp_rst_rv2",   32'(bus.cpu_rvalid), 0);
    chk("resp_rst_rdata", 32'(bus.rdata), 0);
    reset = 1'b0;
    repeat (4) tick();

    // host-only back-to-back reads of 0x00..0x03
    for (int i = 0; i < 4; i++) begin
      gntQ.push_back(1'b1);
      rdQ.push_back('{1'b1, 8'hA0 + 8'(i)});
    end
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("host_gnt",    32'(bus.host_gnt), 1);
      chk("host_starve", 32'(dut.uStarve.count), 0);
      if (i < 3) bus.host_addr = 8'(i + 1);
      else       bus.host_req  = 0;
      tick();
      tick();
    end
    repeat (3) tick();

    chk("gnt_drained", 32'(gntQ.size()), 0);
    chk("rv_drained",  32'(rdQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
